s2p_deframer: RTL
=================

Name: s2p_deframer

Overview:
- Serial-to-parallel receiver: the far end of the PSI serial link.
- Consumes the LSB-first bit stream: idle zeros, SOF dword 0x5a5a5a5a, payload dwords, EOF dword 0x0f0f0f0f, then a 16-bit tail 0x0f0f.
- Recovers payload dwords and presents them as one-cycle pulses with a last-dword marker, plus packet-done and frame-error status.
- Sits on the s_clk domain feeding a downstream sink that cannot apply backpressure.

Parameters:
DSIZE, 32, payload dword width; must be 32 because the marker patterns are 32-bit.
PSIZE, 64, maximum payload dwords per packet.
LSIZE, 7, width of pkt_len; must hold PSIZE, i.e. at least $clog2(PSIZE+1).

Ports:
s_clk  in  1  serial clock, the only clock; all logic on its rising edge.
n_rst  in  1  asynchronous active-low reset.
s_data  in  1  serial line, sampled every rising edge, LSB first.
en  in  1  receiver enable; low forces HUNT.
data  out  DSIZE  recovered payload dword, valid only while valid=1.
valid  out  1  one-cycle strobe per payload dword.
pkt_end  out  1  qualifies valid; marks the last payload dword of a packet.
pkt_done  out  1  one-cycle strobe: tail checked good, packet complete.
pkt_len  out  LSIZE  payload dword count; valid while pkt_done=1.
frame_err  out  1  one-cycle strobe: frame aborted (bad tail or overlength).
busy  out  1  high in any state other than HUNT.

Behaviour:
- Reset, asynchronous: state=HUNT, shift register cleared, bit counter 0, hold register empty. data=0, valid=0, pkt_end=0, pkt_done=0, pkt_len=0, frame_err=0, busy=0.
- Shift register: sh <= {s_data, sh[31:1]} each edge. "nxt" denotes {s_data, sh[31:1]}, the dword completed on the current edge.
- HUNT:
  - sh is cleared on every entry to HUNT.
  - When en=1 and nxt==0x5a5a5a5a: go to DATA, bit counter=0, dword count=0, hold empty.
  - en=0 holds HUNT with sh=0.
- DATA:
  - The bit counter counts 0..31. On count 31 the dword nxt is complete.
  - If nxt==0x0f0f0f0f (EOF): if hold is full, emit the held dword with valid=1 and pkt_end=1 on this edge. Go to TAIL, counter=0.
  - Otherwise it is a payload dword:
    - If the dword count already equals PSIZE: frame_err=1, hold dropped, go to HUNT.
    - Else, if hold is full, emit the held dword with valid=1 and pkt_end=0. Then hold<=nxt and count++.
  - Payload must never contain 0x0f0f0f0f; this is a link-level restriction shared with the transmitter.
- Latency: each payload dword is emitted on the edge that samples the last bit of the following dword or of the EOF marker. That is a 32 s_clk delay from its own final bit.
- TAIL:
  - 16 bits are counted.
  - On the 16th bit, if nxt[31:16]==0x0f0f: pkt_done=1, pkt_len=count.
  - Otherwise: frame_err=1.
  - Either way, go to HUNT.
  - Back-to-back SOF with no idle bits must be detected; sh is zero on entry to HUNT, so the 32 bits that follow fill it.
- Empty packet (SOF immediately followed by EOF): no valid strobe; pkt_done=1 with pkt_len=0.
- Strobes: valid, pkt_done and frame_err are registered and high for exactly one cycle. data holds its last value while valid=0.
- en falling mid-frame: abort to HUNT on the next edge. Hold dropped, no strobes, no frame_err.
- n_rst mid-frame: immediate clear. Partial packet discarded with no strobes.

Decomposition:
- Shared package (psi_defs include):
  - SOF_PAT=32'h5a5a5a5a, EOF_PAT=32'h0f0f0f0f, EOF_TAIL=16'h0f0f.
  - State encodings HUNT/DATA/TAIL, alongside the existing IDLE/SOF/DATA/EOF macros.
- One natural sub-module, s2p_shifter: 32-bit LSB-first shift register plus bit counter, exposing nxt and a word_done flag.
- FSM and hold register live in s2p_deframer.

Test Plan:
- Idle zeros, SOF, dwords 0x12345678 and 0xdeadbeef, EOF, tail → valid twice:
  - 0x12345678 with pkt_end=0.
  - 0xdeadbeef with pkt_end=1, 32 cycles later.
  - pkt_done=1 with pkt_len=2, 16 cycles after EOF completes.
- SOF then EOF then tail → no valid; pkt_done=1, pkt_len=0.
- SOF, 1 dword, EOF, tail=0x0f0e → valid with pkt_end=1, then frame_err=1, pkt_done=0, busy=0.
- SOF plus 65 payload dwords → 63 valid strobes with pkt_end=0, then frame_err=1 on completion of dword 65 (64th dword dropped), return to HUNT.
- Two frames (2 and 3 dwords) back-to-back with no idle bits → 5 valid strobes, pkt_end on the 2nd and 5th, pkt_done twice with pkt_len 2 and 3.
- Reset or en low after 10 bits of dword 2 → busy=0 next cycle, no strobes. A following clean frame decodes correctly.

Source files
------------

// File: rtl/s2p_deframer_pkg.sv
// Shared constants and state encoding for the PSI serial link receiver.
package s2p_deframer_pkg;

  localparam logic [31:0] SOF_PAT  = 32'h5a5a_5a5a;
  localparam logic [31:0] EOF_PAT  = 32'h0f0f_0f0f;
  localparam logic [15:0] EOF_TAIL = 16'h0f0f;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2
  } state_t;

endpackage

// File: rtl/s2p_deframer_if.sv
// Serial line in, recovered dwords and frame status out.
interface s2p_deframer_if #(
  parameter int DSIZE = 32,
  parameter int LSIZE = 7
) ();
  logic             s_data;
  logic             en;
  logic [DSIZE-1:0] data;
  logic             valid;
  logic             pkt_end;
  logic             pkt_done;
  logic [LSIZE-1:0] pkt_len;
  logic             frame_err;
  logic             busy;

  modport master (
    output s_data, en,
    input  data, valid, pkt_end, pkt_done, pkt_len, frame_err, busy
  );

  modport slave (
    input  s_data, en,
    output data, valid, pkt_end, pkt_done, pkt_len, frame_err, busy
  );
endinterface

// File: rtl/s2p_shifter.sv
// LSB-first shift register plus bit counter; nxt is the dword as it stands
// including the bit sampled on the current edge.
module s2p_shifter #(
  parameter int DSIZE = 32
) (
  input  logic             s_clk,
  input  logic             n_rst,
  input  logic             s_data,
  input  logic             clr,
  input  logic             cnt_clr,
  output logic [DSIZE-1:0] nxt,
  output logic [4:0]       cnt,
  output logic             word_done
);
  logic [DSIZE-1:0] sh;

  assign nxt       = {s_data, sh[DSIZE-1:1]};
  assign word_done = (cnt == 5'd31);

  always_ff @(posedge s_clk or negedge n_rst) begin
    if (!n_rst) begin
      sh  <= '0;
      cnt <= '0;
    end else if (clr) begin
      sh  <= '0;
      cnt <= '0;
    end else begin
      sh  <= nxt;
      cnt <= cnt_clr ? 5'd0 : cnt + 5'd1;
    end
  end
endmodule

// File: rtl/s2p_deframer.sv
// PSI serial receiver: hunts SOF, recovers payload dwords through a one-dword
// hold register so the last one can be flagged when EOF arrives.
module s2p_deframer
  import s2p_deframer_pkg::*;
#(
  parameter int DSIZE = 32,
  parameter int PSIZE = 64,
  parameter int LSIZE = 7
) (
  input  logic           s_clk,
  input  logic           n_rst,
  s2p_deframer_if.slave  bus
);
  localparam logic [LSIZE-1:0] PMAX = LSIZE'(PSIZE);

  state_t           state, state_n;
  logic [DSIZE-1:0] nxt;
  logic [4:0]       cnt;
  logic             word_done;
  logic [DSIZE-1:0] hold;
  logic             hold_full;
  logic [LSIZE-1:0] count;

  logic clr, cnt_clr, start, load, emit, emit_last, done, ferr;

  s2p_shifter #(.DSIZE(DSIZE)) u_shifter (
    .s_clk     (s_clk),
    .n_rst     (n_rst),
    .s_data    (bus.s_data),
    .clr       (clr),
    .cnt_clr   (cnt_clr),
    .nxt       (nxt),
    .cnt       (cnt),
    .word_done (word_done)
  );

  always_ff @(posedge s_clk or negedge n_rst) begin
    if (!n_rst) state <= HUNT;
    else        state <= state_n;
  end

  // Every exit to HUNT asserts clr so sh starts empty for the next SOF search.
  always_comb begin
    state_n   = state;
    clr       = 1'b0;
    cnt_clr   = 1'b0;
    start     = 1'b0;
    load      = 1'b0;
    emit      = 1'b0;
    emit_last = 1'b0;
    done      = 1'b0;
    ferr      = 1'b0;
    case (state)
      HUNT: begin
        if (!bus.en) clr = 1'b1;
        else begin
          cnt_clr = 1'b1;
          if (nxt == SOF_PAT) begin
            start   = 1'b1;
            state_n = DATA;
          end
        end
      end
      DATA: begin
        if (!bus.en) begin
          clr     = 1'b1;
          state_n = HUNT;
        end else if (word_done) begin
          if (nxt == EOF_PAT) begin
            emit      = hold_full;
            emit_last = hold_full;
            cnt_clr   = 1'b1;
            state_n   = TAIL;
          end else if (count == PMAX) begin
            ferr    = 1'b1;
            clr     = 1'b1;
            state_n = HUNT;
          end else begin
            emit = hold_full;
            load = 1'b1;
          end
        end
      end
      TAIL: begin
        if (!bus.en) begin
          clr     = 1'b1;
          state_n = HUNT;
        end else if (cnt == 5'd15) begin
          if (nxt[31:16] == EOF_TAIL) done = 1'b1;
          else                        ferr = 1'b1;
          clr     = 1'b1;
          state_n = HUNT;
        end
      end
      default: begin
        clr     = 1'b1;
        state_n = HUNT;
      end
    endcase
  end

  always_ff @(posedge s_clk or negedge n_rst) begin
    if (!n_rst) begin
      hold      <= '0;
      hold_full <= 1'b0;
      count     <= '0;
    end else begin
      if (start || clr) hold_full <= 1'b0;
      else if (load)    hold_full <= 1'b1;
      if (load) hold <= nxt;
      if (start)     count <= '0;
      else if (load) count <= count + LSIZE'(1);
    end
  end

  always_ff @(posedge s_clk or negedge n_rst) begin
    if (!n_rst) begin
      bus.data      <= '0;
      bus.valid     <= 1'b0;
      bus.pkt_end   <= 1'b0;
      bus.pkt_done  <= 1'b0;
      bus.pkt_len   <= '0;
      bus.frame_err <= 1'b0;
    end else begin
      bus.valid     <= emit;
      bus.pkt_end   <= emit_last;
      bus.pkt_done  <= done;
      bus.frame_err <= ferr;
      if (emit) bus.data    <= hold;
      if (done) bus.pkt_len <= count;
    end
  end

  assign bus.busy = (state != HUNT);
endmodule
